// File: rtl/vexec_pkg.sv
// Shared types and helpers for the vector execution sequencer.
// Optional feature macro: VEXEC_MACC_EN (enables the MACC op and its multiplier).
package vexec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_MIN  = 4'd8,
    OP_MAX  = 4'd9,
    OP_MINU = 4'd10,
    OP_MAXU = 4'd11,
    OP_MV   = 4'd12,
    OP_MACC = 4'd13
  } vexec_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_WAIT_DONE,
    ST_FIN
  } vexec_state_t;

  // Encodings 14/15 are never legal; MACC only when the multiplier is built.
  function automatic logic op_is_legal(logic [3:0] op);
    logic legal;
    legal = (op <= OP_MV);
`ifdef VEXEC_MACC_EN
    if (op == OP_MACC) legal = 1'b1;
`endif
    return legal;
  endfunction

  // Number of VRF operands to stream. MACC always needs a, b and the
  // accumulator c (read from vd), so it stays at 3 even in .vx form.
  function automatic logic [1:0] op_num_operands(vexec_op_t op, logic use_scalar);
    if (op == OP_MACC) return 2'd3;
    if (op == OP_MV)   return use_scalar ? 2'd0 : 2'd1;
    return use_scalar ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/vexec_sequencer_if.sv
// VRF request/stream bus between the sequencer (master) and the VRF wrapper (slave).
interface vexec_sequencer_if #(
  parameter int ELEN      = 32,
  parameter int AddrWidth = 5
);
  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] raddr_a;
  logic [AddrWidth-1:0] raddr_b;
  logic [AddrWidth-1:0] waddr;
  logic [1:0]           num_operands;
  logic [ELEN-1:0]      rdata_a;
  logic [ELEN-1:0]      rdata_b;
  logic [ELEN-1:0]      rdata_c;
  logic                 elem_valid;
  logic [ELEN-1:0]      wdata;
  logic                 done;

  modport master (
    output req, we, raddr_a, raddr_b, waddr, num_operands, wdata,
    input  rdata_a, rdata_b, rdata_c, elem_valid, done
  );

  modport slave (
    input  req, we, raddr_a, raddr_b, waddr, num_operands, wdata,
    output rdata_a, rdata_b, rdata_c, elem_valid, done
  );
endinterface

// File: rtl/vexec_elem_alu.sv
// Combinational per-element ALU: result = op(a, b, c) for one ELEN beat.
// Optional feature macro: VEXEC_MACC_EN (instantiates the ELEN x ELEN multiplier).
module vexec_elem_alu
  import vexec_pkg::*;
#(
  parameter int ELEN = 32
) (
  input  vexec_op_t       op,
  input  logic [ELEN-1:0] a,
  input  logic [ELEN-1:0] b,
  input  logic [ELEN-1:0] c,
  output logic [ELEN-1:0] result
);

  localparam int ShW = $clog2(ELEN);

  logic [ShW-1:0]  shamt;
  logic [ELEN-1:0] prod;

  assign shamt = b[ShW-1:0];

  // Without the multiplier the product term is zero; MACC is rejected at
  // accept time in that build, so this path is never selected.
`ifdef VEXEC_MACC_EN
  assign prod = a * b;
`else
  assign prod = '0;
`endif

  // Element operation select.
  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_MIN:  result = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:  result = ($signed(a) > $signed(b)) ? a : b;
      OP_MINU: result = (a < b) ? a : b;
      OP_MAXU: result = (a > b) ? a : b;
      OP_MV:   result = b;
      OP_MACC: result = c + prod;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vexec_sequencer.sv
// Vector instruction sequencer: accepts one decoded instruction, drives the
// VRF request, computes each streamed element and reports done/err.
// Optional feature macro: VEXEC_MACC_EN (MACC op legal, 3-operand fetch).
module vexec_sequencer
  import vexec_pkg::*;
#(
  parameter int VLEN      = 128,
  parameter int ELEN      = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [3:0]           vop_i,
  input  logic                 use_scalar_i,
  input  logic [AddrWidth-1:0] vs1_i,
  input  logic [AddrWidth-1:0] vs2_i,
  input  logic [AddrWidth-1:0] vd_i,
  input  logic [ELEN-1:0]      scalar_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  vexec_sequencer_if.master    vrf
);

  localparam int Count = VLEN / ELEN;
  localparam int CntW  = $clog2(Count + 1);

  vexec_state_t         state_q, state_d;
  logic                 err_q, err_d;
  logic                 legal_q;
  logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
  logic                 latch_en;
  logic                 accept_legal;

  vexec_op_t            op_q;
  logic                 use_scalar_q;
  logic [AddrWidth-1:0] vs1_q, vs2_q, vd_q;
  logic [ELEN-1:0]      scalar_q;

  logic                 active;
  logic                 last_beat;
  logic [ELEN-1:0]      b_sel;
  logic [ELEN-1:0]      alu_result;

  assign accept_legal = op_is_legal(vop_i);
  assign active       = (state_q != ST_IDLE);
  assign last_beat    = vrf.elem_valid && (beat_cnt_q == CntW'(Count - 1));

  // Control state: FSM, error flag, beat counter, legality of the held op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      beat_cnt_q <= '0;
      legal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
      if (latch_en) legal_q <= accept_legal;
    end
  end

  // Instruction fields captured at accept.
  always_ff @(posedge clk_i) begin
    // NOTE: no reset on these data registers; every output they feed is
    // gated by the state, so their value in IDLE is never observed.
    if (latch_en) begin
      op_q         <= vexec_op_t'(vop_i);
      use_scalar_q <= use_scalar_i;
      vs1_q        <= vs1_i;
      vs2_q        <= vs2_i;
      vd_q         <= vd_i;
      scalar_q     <= scalar_i;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    beat_cnt_d    = beat_cnt_q;
    latch_en      = 1'b0;
    instr_ready_o = 1'b0;
    vrf.req       = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          latch_en   = 1'b1;
          beat_cnt_d = '0;
          err_d      = !accept_legal;
          state_d    = accept_legal ? ST_REQ : ST_FIN;
        end
      end
      ST_REQ: begin
        vrf.req = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (vrf.elem_valid) beat_cnt_d = beat_cnt_q + CntW'(1);
        if (last_beat) begin
          // Final beat together with vrf done is a clean completion.
          state_d = vrf.done ? ST_FIN : ST_WAIT_DONE;
        end else if (vrf.done) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_WAIT_DONE: begin
        if (vrf.elem_valid) err_d = 1'b1;
        if (vrf.done) state_d = ST_FIN;
      end
      ST_FIN: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = active;
  assign err_o  = (state_q == ST_FIN) && err_q;

  // Address/control held stable from REQ through FIN, zero in IDLE.
  assign vrf.raddr_a      = active ? vs1_q : '0;
  assign vrf.raddr_b      = active ? vs2_q : '0;
  assign vrf.waddr        = active ? vd_q  : '0;
  assign vrf.we           = active && legal_q;
  assign vrf.num_operands = (active && legal_q) ? op_num_operands(op_q, use_scalar_q) : 2'd0;

  // Operand b: scalar for .vx; a plain vector MV copies operand a.
  assign b_sel = use_scalar_q ? scalar_q :
                 (op_q == OP_MV) ? vrf.rdata_a : vrf.rdata_b;

  vexec_elem_alu #(
    .ELEN (ELEN)
  ) u_alu (
    .op     (op_q),
    .a      (vrf.rdata_a),
    .b      (b_sel),
    .c      (vrf.rdata_c),
    .result (alu_result)
  );

  assign vrf.wdata = (state_q == ST_RUN) ? alu_result : '0;

endmodule
